// File: rtl/gpio_bank_ctrl.sv
// gpio_bank_ctrl: register-programmed GPIO bank with output/direction
// registers, 2-FF input synchroniser, per-pin debounce, and sticky
// rise/fall edge capture that drives a level interrupt.
//
// Register port handshake: reg_we/reg_re are single-cycle strobes sampled
// on a clock edge; reg_ack is high for exactly the following cycle with
// reg_rdata valid (zero otherwise). A write is committed on the edge that
// ends the ack cycle. With both strobes high only the write happens and
// rdata is zero. While en=0 write strobes are dropped (no ack), reads are
// still acknowledged.
module gpio_bank_ctrl #(
    parameter int NPINS = 34,
    parameter int DB_W  = 8
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en,
    input  logic [NPINS-1:0] gpio_in,
    output logic [NPINS-1:0] gpio_out,
    output logic [NPINS-1:0] gpio_oeb,
    input  logic [2:0]       reg_addr,
    input  logic [NPINS-1:0] reg_wdata,
    input  logic             reg_we,
    input  logic             reg_re,
    output logic [NPINS-1:0] reg_rdata,
    output logic             reg_ack,
    output logic             irq
);

    localparam int WW = (NPINS > DB_W) ? NPINS : DB_W;

    localparam logic [2:0] A_DATA_OUT = 3'd0;
    localparam logic [2:0] A_OEB      = 3'd1;
    localparam logic [2:0] A_DATA_IN  = 3'd2;
    localparam logic [2:0] A_RISE_EN  = 3'd3;
    localparam logic [2:0] A_FALL_EN  = 3'd4;
    localparam logic [2:0] A_EDGE     = 3'd5;
    localparam logic [2:0] A_DEBOUNCE = 3'd6;

    // Programmable registers
    logic [NPINS-1:0] data_out_q;
    logic [NPINS-1:0] oeb_q;
    logic [NPINS-1:0] rise_en_q;
    logic [NPINS-1:0] fall_en_q;
    logic [NPINS-1:0] status_q;
    logic [DB_W-1:0]  debounce_q;

    // Pending write captured with the strobe, committed one cycle later
    logic             pend_we_q;
    logic [2:0]       pend_addr_q;
    logic [NPINS-1:0] pend_wdata_q;

    // Register port response
    logic             ack_q;
    logic [NPINS-1:0] rdata_q;

    // Pin-side registers
    logic [NPINS-1:0] out_pin_q;
    logic [NPINS-1:0] oeb_pin_q;
    logic             irq_q;

    // Input path
    logic [NPINS-1:0] sync1_q;
    logic [NPINS-1:0] sync2_q;
    logic [NPINS-1:0] stable_q;
    logic [NPINS-1:0] stable_d;
    logic [DB_W-1:0]  cnt_q [NPINS];
    logic [DB_W-1:0]  cnt_d [NPINS];

    logic             wr_req;
    logic             rd_req;
    logic [NPINS-1:0] rd_mux;
    logic [WW-1:0]    db_wide;
    logic [WW-1:0]    wdata_wide;
    logic [NPINS-1:0] rise_ev;
    logic [NPINS-1:0] fall_ev;
    logic [NPINS-1:0] clr_mask;
    logic [NPINS-1:0] status_d;

    assign wr_req     = reg_we & en;
    assign rd_req     = reg_re & ~wr_req;
    assign db_wide    = WW'(debounce_q);
    assign wdata_wide = WW'(pend_wdata_q);

    // Read data mux over the current register contents
    always_comb begin
        rd_mux = '0;
        case (reg_addr)
            A_DATA_OUT: rd_mux = data_out_q;
            A_OEB:      rd_mux = oeb_q;
            A_DATA_IN:  rd_mux = stable_q;
            A_RISE_EN:  rd_mux = rise_en_q;
            A_FALL_EN:  rd_mux = fall_en_q;
            A_EDGE:     rd_mux = status_q;
            A_DEBOUNCE: rd_mux = db_wide[NPINS-1:0];
            default:    rd_mux = '0;
        endcase
    end

    // Capture the request and produce the one-cycle ack with read data
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pend_we_q    <= 1'b0;
            pend_addr_q  <= '0;
            pend_wdata_q <= '0;
            ack_q        <= 1'b0;
            rdata_q      <= '0;
        end else begin
            pend_we_q <= wr_req;
            if (wr_req) begin
                pend_addr_q  <= reg_addr;
                pend_wdata_q <= reg_wdata;
            end
            ack_q   <= wr_req | reg_re;
            rdata_q <= rd_req ? rd_mux : '0;
        end
    end

    // Commit pending writes to the RW registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            data_out_q <= '0;
            oeb_q      <= '1;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            debounce_q <= '0;
        end else if (pend_we_q) begin
            case (pend_addr_q)
                A_DATA_OUT: data_out_q <= pend_wdata_q;
                A_OEB:      oeb_q      <= pend_wdata_q;
                A_RISE_EN:  rise_en_q  <= pend_wdata_q;
                A_FALL_EN:  fall_en_q  <= pend_wdata_q;
                A_DEBOUNCE: debounce_q <= wdata_wide[DB_W-1:0];
                default:    ;
            endcase
        end
    end

    // Two-flop synchroniser; keeps sampling even while disabled
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= gpio_in;
            sync2_q <= sync2_q == sync2_q ? sync1_q : sync1_q;
        end
    end

    // Per-pin debounce: count cycles of disagreement, accept at threshold
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < NPINS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (en) begin
                if (sync2_q[i] == stable_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] >= debounce_q) begin
                    stable_d[i] = sync2_q[i];
                    cnt_d[i]    = '0;
                end else if (cnt_q[i] != {DB_W{1'b1}}) begin
                    cnt_d[i] = cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    // Debounce state registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            stable_q <= '0;
            for (int i = 0; i < NPINS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // Edge detection on the debounced value; a new edge beats a same-cycle clear
    always_comb begin
        rise_ev  = stable_d & ~stable_q & rise_en_q;
        fall_ev  = ~stable_d & stable_q & fall_en_q;
        clr_mask = (pend_we_q && (pend_addr_q == A_EDGE)) ? pend_wdata_q : '0;
        status_d = (status_q & ~clr_mask) | rise_ev | fall_ev;
    end

    // Sticky status, registered interrupt and registered pin outputs
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            status_q  <= '0;
            irq_q     <= 1'b0;
            out_pin_q <= '0;
            oeb_pin_q <= '1;
        end else begin
            status_q  <= status_d;
            irq_q     <= |status_q;
            out_pin_q <= data_out_q;
            oeb_pin_q <= oeb_q;
        end
    end

    assign gpio_out  = en ? out_pin_q : '0;
    assign gpio_oeb  = en ? oeb_pin_q : '1;
    assign irq       = en & irq_q;
    assign reg_ack   = ack_q;
    assign reg_rdata = rdata_q;

endmodule

// File: tb/tb_gpio_bank_ctrl.sv
// tb_gpio_bank_ctrl: directed table + multi-cycle sequences, then random
// traffic checked cycle by cycle against a behavioural model.
module tb_gpio_bank_ctrl;

    localparam int NPINS = 34;
    localparam int DB_W  = 8;
    typedef logic [NPINS-1:0] vec_t;
    localparam vec_t ALL1 = '1;

    logic       clk;
    logic       nrst;
    logic       en;
    vec_t       gpio_in;
    vec_t       gpio_out;
    vec_t       gpio_oeb;
    logic [2:0] reg_addr;
    vec_t       reg_wdata;
    logic       reg_we;
    logic       reg_re;
    vec_t       reg_rdata;
    logic       reg_ack;
    logic       irq;

    int total = 0;
    int bad   = 0;
    bit chk_model = 0;

    gpio_bank_ctrl #(.NPINS(NPINS), .DB_W(DB_W)) dut (
        .clk(clk), .nrst(nrst), .en(en), .gpio_in(gpio_in),
        .gpio_out(gpio_out), .gpio_oeb(gpio_oeb),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
        .reg_re(reg_re), .reg_rdata(reg_rdata), .reg_ack(reg_ack), .irq(irq)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // ---------------- behavioural reference model ----------------
    // Registers as plain values; debounce as "age of disagreement" per pin:
    // a pin's accepted value flips once sync has disagreed with it for more
    // than DEBOUNCE enabled cycles in a row.
    vec_t m_data_out, m_oeb, m_rise, m_fall, m_status, m_stable, m_s1, m_s2;
    vec_t m_out, m_oebq, m_rdata, m_pwdata;
    int   m_db;
    int   m_age [NPINS];
    bit   m_pw, m_ack, m_irq;
    logic [2:0] m_paddr;

    function automatic void model_reset();
        m_data_out = '0; m_oeb = ALL1; m_rise = '0; m_fall = '0;
        m_status = '0; m_stable = '0; m_s1 = '0; m_s2 = '0;
        m_out = '0; m_oebq = ALL1; m_rdata = '0; m_pwdata = '0;
        m_db = 0; m_pw = 0; m_ack = 0; m_irq = 0; m_paddr = '0;
        for (int i = 0; i < NPINS; i++) m_age[i] = 0;
    endfunction

    function automatic vec_t model_read(logic [2:0] a);
        case (a)
            3'd0: return m_data_out;
            3'd1: return m_oeb;
            3'd2: return m_stable;
            3'd3: return m_rise;
            3'd4: return m_fall;
            3'd5: return m_status;
            3'd6: return vec_t'(m_db);
            default: return '0;
        endcase
    endfunction

    function automatic void model_step();
        vec_t new_stable = m_stable;
        vec_t edges, clr, rd;
        bit   wr;
        for (int i = 0; i < NPINS; i++) begin
            if (en) begin
                if (m_s2[i] != m_stable[i]) begin
                    m_age[i]++;
                    if (m_age[i] > m_db) begin
                        new_stable[i] = m_s2[i];
                        m_age[i] = 0;
                    end
                end else begin
                    m_age[i] = 0;
                end
            end
        end
        edges = (new_stable & ~m_stable & m_rise) | (~new_stable & m_stable & m_fall);
        rd = model_read(reg_addr);
        m_out  = m_data_out;
        m_oebq = m_oeb;
        m_irq  = (m_status != 0);
        clr = (m_pw && m_paddr == 3'd5) ? m_pwdata : '0;
        m_status = (m_status & ~clr) | edges;
        if (m_pw) begin
            case (m_paddr)
                3'd0: m_data_out = m_pwdata;
                3'd1: m_oeb = m_pwdata;
                3'd3: m_rise = m_pwdata;
                3'd4: m_fall = m_pwdata;
                3'd6: m_db = int'(m_pwdata[DB_W-1:0]);
                default: ;
            endcase
        end
        wr = reg_we && en;
        m_pw = wr;
        if (wr) begin
            m_paddr = reg_addr;
            m_pwdata = reg_wdata;
        end
        m_ack = wr || reg_re;
        m_rdata = (reg_re && !wr) ? rd : '0;
        m_stable = new_stable;
        m_s2 = m_s1;
        m_s1 = gpio_in;
    endfunction

    function automatic void compare_model();
        check("rnd_gpio_out", gpio_out, en ? m_out : '0);
        check("rnd_gpio_oeb", gpio_oeb, en ? m_oebq : ALL1);
        check("rnd_irq", irq, en & m_irq);
        check("rnd_ack", reg_ack, m_ack);
        check("rnd_rdata", reg_rdata, m_rdata);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        if (nrst) model_step();
        @(negedge clk);
        if (chk_model) compare_model();
    endtask

    task automatic ticks(int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic reg_op(input logic [2:0] a, input vec_t d, input logic we,
                          input logic re, output logic ack, output vec_t rd);
        reg_addr = a; reg_wdata = d; reg_we = we; reg_re = re;
        tick();
        ack = reg_ack;
        rd  = reg_rdata;
        reg_we = 1'b0; reg_re = 1'b0;
        if (we) tick();
    endtask

    task automatic reg_write(input logic [2:0] a, input vec_t d, input string name);
        logic ack; vec_t rd;
        reg_op(a, d, 1'b1, 1'b0, ack, rd);
        check({name, "_ack"}, ack, 1'b1);
    endtask

    task automatic reg_read(input logic [2:0] a, input vec_t exp, input string name);
        logic ack; vec_t rd;
        reg_op(a, '0, 1'b0, 1'b1, ack, rd);
        check({name, "_ack"}, ack, 1'b1);
        check(name, rd, exp);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [2:0] addr;
        vec_t       wdata;
        logic       we;
        logic       re;
        logic       exp_ack;
        vec_t       exp_rdata;
    } row_t;
    row_t tbl [18];

    function automatic void set_row(int i, logic [2:0] a, vec_t d, logic we,
                                    logic re, logic ea, vec_t er);
        tbl[i].addr = a; tbl[i].wdata = d; tbl[i].we = we; tbl[i].re = re;
        tbl[i].exp_ack = ea; tbl[i].exp_rdata = er;
    endfunction

    initial begin
        logic ack;
        vec_t rd;

        set_row(0,  3'd0, '0, 0, 1, 1, 34'h155);
        set_row(1,  3'd1, '0, 0, 1, 1, 34'h0);
        set_row(2,  3'd3, 34'h2_AAAA_5555, 1, 0, 1, '0);
        set_row(3,  3'd3, '0, 0, 1, 1, 34'h2_AAAA_5555);
        set_row(4,  3'd4, 34'h1_5555_AAAA, 1, 0, 1, '0);
        set_row(5,  3'd4, '0, 0, 1, 1, 34'h1_5555_AAAA);
        set_row(6,  3'd6, 34'h3_FFFF_FF37, 1, 0, 1, '0);
        set_row(7,  3'd6, '0, 0, 1, 1, 34'h37);
        set_row(8,  3'd7, ALL1, 1, 0, 1, '0);
        set_row(9,  3'd7, '0, 0, 1, 1, '0);
        set_row(10, 3'd2, ALL1, 1, 0, 1, '0);
        set_row(11, 3'd2, '0, 0, 1, 1, '0);
        set_row(12, 3'd0, 34'hAA, 1, 1, 1, '0);
        set_row(13, 3'd0, '0, 0, 1, 1, 34'hAA);
        set_row(14, 3'd5, '0, 0, 1, 1, '0);
        set_row(15, 3'd3, '0, 1, 0, 1, '0);
        set_row(16, 3'd4, '0, 1, 0, 1, '0);
        set_row(17, 3'd6, '0, 1, 0, 1, '0);

        nrst = 1'b0; en = 1'b1; gpio_in = '0;
        reg_addr = '0; reg_wdata = '0; reg_we = 1'b0; reg_re = 1'b0;

        // reset held while pads toggle
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            gpio_in = ~gpio_in;
        end
        @(negedge clk);
        check("rst_gpio_oeb", gpio_oeb, ALL1);
        check("rst_gpio_out", gpio_out, '0);
        check("rst_irq", irq, 1'b0);
        check("rst_ack", reg_ack, 1'b0);
        gpio_in = '0;
        nrst = 1'b1;
        model_reset();
        ticks(4);
        reg_read(3'd1, ALL1, "rst_oeb_read");

        // output data/direction and their pin timing
        reg_write(3'd0, 34'h155, "wr_data_out");
        check("gpio_out_not_yet", gpio_out, '0);
        tick();
        check("gpio_out_155", gpio_out, 34'h155);
        reg_write(3'd1, '0, "wr_oeb");
        check("gpio_oeb_not_yet", gpio_oeb, ALL1);
        tick();
        check("gpio_oeb_0", gpio_oeb, '0);

        // table-driven register accesses
        for (int i = 0; i < 18; i++) begin
            reg_op(tbl[i].addr, tbl[i].wdata, tbl[i].we, tbl[i].re, ack, rd);
            check($sformatf("tbl%0d_ack", i), ack, tbl[i].exp_ack);
            check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
        end

        // debounce: short glitch rejected, long pulse accepted at 2+5 cycles
        reg_write(3'd6, 34'd4, "wr_db4");
        reg_write(3'd3, 34'h1, "wr_rise1");
        gpio_in[0] = 1'b1;
        ticks(3);
        gpio_in[0] = 1'b0;
        ticks(10);
        reg_read(3'd2, '0, "glitch_data_in");
        reg_read(3'd5, '0, "glitch_status");
        gpio_in[0] = 1'b1;
        ticks(6);
        reg_read(3'd2, '0, "db_data_in_early");
        reg_read(3'd2, 34'h1, "db_data_in_on_time");
        reg_read(3'd5, 34'h1, "db_status");
        check("db_irq", irq, 1'b1);
        reg_write(3'd5, 34'h1, "db_w1c");
        tick();
        check("db_irq_clear", irq, 1'b0);
        gpio_in[0] = 1'b0;
        ticks(10);

        // edge capture with debounce bypassed
        reg_write(3'd6, '0, "wr_db0");
        reg_write(3'd4, 34'h2, "wr_fall2");
        reg_read(3'd5, '0, "edge_status_idle");
        gpio_in[0] = 1'b1;
        ticks(5);
        reg_read(3'd5, 34'h1, "edge_rise0");
        check("edge_irq", irq, 1'b1);
        gpio_in[1] = 1'b1;
        ticks(5);
        reg_read(3'd5, 34'h1, "edge_rise1_ignored");
        gpio_in[1] = 1'b0;
        ticks(5);
        reg_read(3'd5, 34'h3, "edge_fall1");
        reg_write(3'd5, 34'h1, "w1c_bit0");
        reg_read(3'd5, 34'h2, "status_after_w1c0");
        check("irq_held", irq, 1'b1);
        reg_write(3'd5, 34'h2, "w1c_bit1");
        tick();
        check("irq_dropped", irq, 1'b0);
        reg_read(3'd5, '0, "status_empty");

        // same-cycle clear and new rising edge on pin0
        gpio_in[0] = 1'b0;
        ticks(5);
        gpio_in[0] = 1'b1;
        ticks(5);
        gpio_in[0] = 1'b0;
        ticks(5);
        reg_read(3'd5, 34'h1, "pre_collide_status");
        gpio_in[0] = 1'b1;
        tick();
        reg_write(3'd5, 34'h1, "collide_w1c");
        reg_read(3'd5, 34'h1, "collide_set_wins");
        reg_write(3'd5, 34'h1, "plain_w1c");
        reg_read(3'd5, '0, "plain_w1c_clears");

        // block disable
        reg_write(3'd0, 34'hFF, "wr_data_ff");
        reg_write(3'd4, 34'h3, "wr_fall3");
        gpio_in[0] = 1'b0;
        ticks(5);
        reg_read(3'd5, 34'h1, "en_status_set");
        ticks(2);
        check("en1_irq", irq, 1'b1);
        check("en1_gpio_out", gpio_out, 34'hFF);
        en = 1'b0;
        #1;
        check("en0_gpio_out", gpio_out, '0);
        check("en0_gpio_oeb", gpio_oeb, ALL1);
        check("en0_irq", irq, 1'b0);
        reg_op(3'd0, '0, 1'b1, 1'b0, ack, rd);
        check("en0_write_no_ack", ack, 1'b0);
        tick();
        reg_read(3'd0, 34'hFF, "en0_read_data_out");
        gpio_in[0] = 1'b1;
        ticks(6);
        reg_read(3'd2, '0, "en0_data_in_frozen");
        en = 1'b1;
        #1;
        check("en_back_gpio_out", gpio_out, 34'hFF);
        check("en_back_gpio_oeb", gpio_oeb, '0);
        check("en_back_irq", irq, 1'b1);
        ticks(4);
        reg_read(3'd2, 34'h1, "en_back_data_in");

        // asynchronous reset while an ack is pending
        @(negedge clk);
        reg_addr = 3'd1; reg_re = 1'b1;
        @(posedge clk);
        #1;
        check("pre_reset_ack", reg_ack, 1'b1);
        nrst = 1'b0;
        #1;
        check("async_rst_ack", reg_ack, 1'b0);
        check("async_rst_oeb", gpio_oeb, ALL1);
        check("async_rst_out", gpio_out, '0);
        check("async_rst_irq", irq, 1'b0);
        reg_re = 1'b0;
        gpio_in = '0;
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;
        model_reset();

        // randomized traffic against the model
        chk_model = 1;
        for (int c = 0; c < 1500; c++) begin
            int r;
            if ($urandom_range(0, 3) == 0)
                gpio_in[$urandom_range(0, 5)] ^= 1'b1;
            if ($urandom_range(0, 3) == 0)
                gpio_in[$urandom_range(0, NPINS-1)] ^= 1'b1;
            if ($urandom_range(0, 59) == 0) en = ~en;
            r = $urandom_range(0, 7);
            reg_we = (r == 0 || r == 1 || r == 4);
            reg_re = (r == 2 || r == 3 || r == 4);
            reg_addr = 3'($urandom_range(0, 7));
            reg_wdata = vec_t'({$urandom, $urandom});
            if (reg_addr == 3'd6) reg_wdata = vec_t'($urandom_range(0, 5));
            tick();
        end
        reg_we = 1'b0; reg_re = 1'b0;
        tick();
        chk_model = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpio_bank_ctrl.md
Name: gpio_bank_ctrl

Overview:
- Parametrised GPIO bank that sits between a team project's core logic and the breakout-board pins (gpio_in/gpio_out/gpio_oeb).
- Provides per-pin output data and direction registers, a 2-FF input synchroniser, per-pin debounce, and rise/fall edge capture with sticky status and an interrupt.
- Programmed through a simple single-cycle register port driven by the project core or a bus adapter.

Parameters:
- NPINS, 34, number of pins in the bank (1..34).
- DB_W, 8, width of the per-pin debounce counter and DEBOUNCE register.

Ports:
- clk  input  1  system clock
- nrst  input  1  asynchronous active-low reset
- en  input  1  block enable; low forces pins safe and freezes state
- gpio_in  input  NPINS  raw pad inputs
- gpio_out  output  NPINS  pad output data
- gpio_oeb  output  NPINS  active-low output enable per pin
- reg_addr  input  3  register index
- reg_wdata  input  NPINS  write data
- reg_we  input  1  write strobe, one cycle
- reg_re  input  1  read strobe, one cycle
- reg_rdata  output  NPINS  read data, valid while reg_ack=1
- reg_ack  output  1  one-cycle acknowledge
- irq  output  1  level interrupt, OR of EDGE_STATUS

Behaviour:
- Reset values: all registers 0 except OEB = all 1s (all pins input).
  - Outputs: gpio_out=0, gpio_oeb=all 1s, reg_rdata=0, reg_ack=0, irq=0.
  - Synchronisers, stable values and debounce counters = 0.
- Register map:
  - 0 DATA_OUT (RW)
  - 1 OEB (RW)
  - 2 DATA_IN (RO, debounced stable value)
  - 3 RISE_EN (RW)
  - 4 FALL_EN (RW)
  - 5 EDGE_STATUS (RW, write-1-to-clear)
  - 6 DEBOUNCE (RW, low DB_W bits used, upper bits read 0)
  - 7 reserved: reads 0, writes ignored
- Register port:
  - Strobe sampled at cycle N. reg_ack=1 and reg_rdata valid in cycle N+1 only.
  - reg_rdata returns 0 when reg_ack=0.
  - Writes take effect at the cycle N+1 edge.
  - reg_we and reg_re high together: the write is performed, the read is ignored, and a single ack is returned with rdata=0.
  - Writes to RO or reserved addresses are acked and have no effect.
- Pin outputs: gpio_out = DATA_OUT and gpio_oeb = OEB, registered, so they change one cycle after the write ack edge.
- Input path:
  - gpio_in passes through 2 flops to give sync; DATA_IN sees gpio_in changes no earlier than 2 cycles later.
  - Per pin, when sync == stable: counter cleared.
  - Per pin, when sync != stable: counter increments each cycle. When the counter reaches DEBOUNCE: stable <= sync and counter <= 0.
  - DEBOUNCE=0 bypasses the filter; stable follows sync one cycle later (total 3 cycles pin-to-DATA_IN).
  - A glitch shorter than DEBOUNCE cycles never reaches stable, because the counter clears when sync returns.
  - Counter saturates at all 1s and cannot wrap.
  - Changing DEBOUNCE mid-count: the new threshold applies immediately. If the counter is already >= the new value, the update occurs next cycle.
- Edge capture:
  - Rising transition of stable with RISE_EN[i]=1 sets EDGE_STATUS[i].
  - Falling transition of stable with FALL_EN[i]=1 sets EDGE_STATUS[i].
  - Status is sticky until cleared by W1C.
  - Same-cycle W1C and new edge on the same bit: set wins.
  - Disabling RISE_EN/FALL_EN does not clear existing status bits.
- irq = |EDGE_STATUS, registered, asserted the cycle after the status bit sets.
- en=0:
  - gpio_out forced to 0 and gpio_oeb forced to all 1s combinationally.
  - Register writes ignored (no ack); reads still acked.
  - Debounce counters and edge capture frozen; synchronisers keep sampling.
  - irq forced 0.
  - Register contents retained; outputs resume on the cycle en returns to 1.
- Reset asserted mid-operation clears everything asynchronously, including a pending ack.

Test Plan:
- Reset: hold nrst=0, toggle gpio_in -> gpio_oeb=all 1s, gpio_out=0, irq=0; read OEB after release -> 0x3_FFFF_FFFF (NPINS=34).
- Write DATA_OUT=0x155, OEB=0x0 -> reg_ack one cycle after each write; gpio_out=0x155 and gpio_oeb=0 one cycle after the ack; read DATA_OUT -> 0x155.
- DEBOUNCE=4, gpio_in[0] high for 3 cycles then low -> DATA_IN[0] stays 0, no status set. Held high for 10 cycles -> DATA_IN[0]=1 at 2+5 cycles after the edge.
- RISE_EN=0x1, FALL_EN=0x2, DEBOUNCE=0:
  - Raise pin0 -> EDGE_STATUS=0x1, irq=1.
  - Raise then lower pin1 -> bit1 sets only on the fall.
  - Write EDGE_STATUS=0x1 -> bit0 clears, irq stays 1 until 0x2 is also written.
- Simultaneous clear and new edge on pin0 in the same cycle -> EDGE_STATUS[0] remains 1.
- en=0 with DATA_OUT=0xFF, OEB=0 -> gpio_oeb=all 1s, gpio_out=0, a write to DATA_OUT is not acked and has no effect; en=1 -> gpio_out=0xFF restored.
